regfile_mp_scoreboard: RTL

//  Parametrised multi-port register file for the MIPS datapath.

---
 rtl/regfile_mp_scoreboard.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard
//   Multi-port register file for the MIPS datapath with a per-register busy
//   scoreboard. Decode reads operands and marks destinations busy on issue;
//   write-back commits results on two write ports, clearing busy.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   NUM_RD   number of combinational read ports (1..4)
//   ZERO_REG 1: register 0 is hard-wired zero, never written, never busy
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   rd_addr / rd_data        packed read ports, port k at [k*W +: W]
//   rd_busy                  busy bit of each read address
//   wr0_* (ALU), wr1_* (load) write ports; wr1 wins on same address
//   sb_set_en / sb_set_addr  mark destination busy at issue
//   dbg_regs                 flattened raw register contents (never forwarded)
//
// Configuration
//   REGFILE_BYPASS_EN defined: same-cycle write data / busy clear is forwarded
//   to the read ports. Undefined: writes are visible the cycle after the edge.

module regfile_mp_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]         rd_addr,
    output logic [NUM_RD*DATA_W-1:0]         rd_data,
    output logic [NUM_RD-1:0]                rd_busy,
    input  logic                             wr0_en,
    input  logic [ADDR_W-1:0]                wr0_addr,
    input  logic [DATA_W-1:0]                wr0_data,
    input  logic                             wr1_en,
    input  logic [ADDR_W-1:0]                wr1_addr,
    input  logic [DATA_W-1:0]                wr1_data,
    input  logic                             sb_set_en,
    input  logic [ADDR_W-1:0]                sb_set_addr,
    output logic [(2**ADDR_W)*DATA_W-1:0]    dbg_regs
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] r_regs;
    logic [DEPTH-1:0]             r_busy;

    // Qualified requests: anything aimed at the zero register is dropped.
    logic w_wr0_ok, w_wr1_ok, w_set_ok;
    assign w_wr0_ok = wr0_en    && !(ZERO_REG != 0 && wr0_addr    == '0);
    assign w_wr1_ok = wr1_en    && !(ZERO_REG != 0 && wr1_addr    == '0);
    assign w_set_ok = sb_set_en && !(ZERO_REG != 0 && sb_set_addr == '0);

    // Later non-blocking assignments win: wr1 over wr0 for data,
    // set over clear for busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr0_ok) begin
                r_regs[wr0_addr] <= wr0_data;
                r_busy[wr0_addr] <= 1'b0;
            end
            if (w_wr1_ok) begin
                r_regs[wr1_addr] <= wr1_data;
                r_busy[wr1_addr] <= 1'b0;
            end
            if (w_set_ok)
                r_busy[sb_set_addr] <= 1'b1;
        end
    end

    assign dbg_regs = r_regs;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_d;
        logic              w_b;

        assign w_a = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_d = r_regs[w_a];
            w_b = r_busy[w_a];
`ifdef REGFILE_BYPASS_EN
            if (w_wr1_ok && wr1_addr == w_a)
                w_d = wr1_data;
            else if (w_wr0_ok && wr0_addr == w_a)
                w_d = wr0_data;
            // A producer completing this cycle releases the operand unless a
            // newer producer is being issued to the same register right now.
            if (((w_wr1_ok && wr1_addr == w_a) || (w_wr0_ok && wr0_addr == w_a)) &&
                !(w_set_ok && sb_set_addr == w_a))
                w_b = 1'b0;
`endif
            if (ZERO_REG != 0 && w_a == '0) begin
                w_d = '0;
                w_b = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_d;
        assign rd_busy[k]                  = w_b;
    end

endmodule
